// File: rtl/level_bar_pkg.sv
// Shared colour constants, mode encodings and the bar gradient function.
// Latency: pure combinational helpers, no state.
// Backpressure: not applicable.
package level_bar_pkg;

  localparam logic [11:0] BLACK = 12'h000;
  localparam logic [11:0] WHITE = 12'hFFF;
  localparam logic [11:0] MONO  = 12'h0F0;

  typedef enum logic [1:0] {
    MODE_GRAD = 2'd0,
    MODE_MONO = 2'd1,
    MODE_INV  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  // Red-to-yellow over the lower half, yellow-to-green over the upper half.
  // For g in 16..31, 31-g equals the bitwise inverse of the low nibble.
  function automatic logic [11:0] gradient_color(input logic [4:0] g);
    if (!g[4]) begin
      return {4'hF, g[3:0], 4'h0};
    end else begin
      return {~g[3:0], 4'hF, 4'h0};
    end
  endfunction

endpackage

// File: rtl/level_peak_tracker.sv
// Holds the smoothed bar level, the peak-hold marker and its hold counter.
// Latency: a sample or tick is reflected on the outputs one cycle later.
// Backpressure: none; every level sample and tick is consumed immediately.
module level_peak_tracker
  import level_bar_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 5,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               level_valid,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               tick,
  output logic [LEVEL_W-1:0] bar_level,
  output logic [LEVEL_W-1:0] peak_level
);

  localparam int unsigned HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

  logic [LEVEL_W-1:0] r_bar;
  logic [LEVEL_W-1:0] r_peak;
  logic [HOLD_W-1:0]  r_hold;

  logic [LEVEL_W-1:0] w_bar_dec;
  logic [LEVEL_W-1:0] w_bar_next;
  logic [LEVEL_W-1:0] w_peak_dec;
  logic [LEVEL_W-1:0] w_peak_fall;
  logic               w_peak_load;

  // Subtract one decay step, clamping at zero; done in 32 bits so a step
  // larger than the level range still saturates correctly.
  function automatic logic [LEVEL_W-1:0] sat_sub(input logic [LEVEL_W-1:0] v);
    if (32'(v) > DECAY_STEP) begin
      return LEVEL_W'(32'(v) - DECAY_STEP);
    end else begin
      return '0;
    end
  endfunction

  // Next bar value: decay on tick, then a new sample wins if it is larger.
  always_comb begin
    w_bar_dec  = tick ? sat_sub(r_bar) : r_bar;
    w_bar_next = w_bar_dec;
    if (level_valid && (level_in > w_bar_dec)) begin
      w_bar_next = level_in;
    end
    w_peak_dec  = sat_sub(r_peak);
    w_peak_fall = (w_peak_dec > w_bar_next) ? w_peak_dec : w_bar_next;
    w_peak_load = level_valid && (level_in >= r_peak);
  end

  // Bar, peak and hold counter; a falling peak is never allowed below the bar.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bar  <= '0;
      r_peak <= '0;
      r_hold <= '0;
    end else begin
      r_bar <= w_bar_next;
      if (w_peak_load) begin
        r_peak <= level_in;
        r_hold <= HOLD_W'(HOLD_TICKS);
      end else if (tick) begin
        if (r_hold != '0) begin
          r_hold <= r_hold - 1'b1;
        end else begin
          r_peak <= w_peak_fall;
        end
      end
    end
  end

  assign bar_level  = r_bar;
  assign peak_level = r_peak;

endmodule

// File: rtl/level_bar_renderer.sv
// Renders a level bar with peak marker as RGB444 colours for per-row queries.
// Latency: color_valid/color follow query_valid by exactly 2 cycles.
// Backpressure: none; one query accepted every cycle, results never stall.
module level_bar_renderer
  import level_bar_pkg::*;
#(
  parameter int unsigned LEVEL_W    = 5,
  parameter int unsigned HOLD_TICKS = 8,
  parameter int unsigned DECAY_STEP = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic               peak_en,
  input  logic               level_valid,
  input  logic [LEVEL_W-1:0] level_in,
  input  logic               tick,
  input  logic               query_valid,
  input  logic [LEVEL_W-1:0] query_row,
  output logic               color_valid,
  output logic [11:0]        color,
  output logic [LEVEL_W-1:0] bar_level,
  output logic [LEVEL_W-1:0] peak_level
);

  logic [LEVEL_W-1:0] w_bar;
  logic [LEVEL_W-1:0] w_peak;
  logic [4:0]         w_g;
  logic [11:0]        w_pix;

  logic               r_s1_vld;
  logic               r_s1_en;
  mode_e              r_s1_mode;
  logic               r_s1_peak_hit;
  logic               r_s1_in_bar;
  logic [4:0]         r_s1_g;

  logic               r_s2_vld;
  logic [11:0]        r_s2_color;

  level_peak_tracker #(
    .LEVEL_W    (LEVEL_W),
    .HOLD_TICKS (HOLD_TICKS),
    .DECAY_STEP (DECAY_STEP)
  ) u_tracker (
    .clk         (clk),
    .reset       (reset),
    .level_valid (level_valid),
    .level_in    (level_in),
    .tick        (tick),
    .bar_level   (w_bar),
    .peak_level  (w_peak)
  );

  // Scale the row onto the fixed 32-entry gradient regardless of LEVEL_W.
  if (LEVEL_W <= 5) begin : g_scale_up
    assign w_g = 5'(query_row) << (5 - LEVEL_W);
  end else begin : g_scale_down
    assign w_g = 5'(query_row >> (LEVEL_W - 5));
  end

  // Stage 1: capture comparison flags against the bar/peak seen in the query cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_vld      <= 1'b0;
      r_s1_en       <= 1'b0;
      r_s1_mode     <= MODE_GRAD;
      r_s1_peak_hit <= 1'b0;
      r_s1_in_bar   <= 1'b0;
      r_s1_g        <= '0;
    end else begin
      r_s1_vld <= query_valid;
      if (query_valid) begin
        r_s1_en       <= enable;
        r_s1_mode     <= mode_e'(mode);
        r_s1_peak_hit <= peak_en && (query_row == w_peak) && (w_peak != '0);
        r_s1_in_bar   <= query_row < w_bar;
        r_s1_g        <= w_g;
      end
    end
  end

  // Colour priority: disabled, then peak marker, then bar body, else background.
  always_comb begin
    w_pix = BLACK;
    if (!r_s1_en) begin
      w_pix = BLACK;
    end else if (r_s1_peak_hit) begin
      w_pix = WHITE;
    end else if (r_s1_in_bar) begin
      case (r_s1_mode)
        MODE_MONO: w_pix = MONO;
        MODE_INV:  w_pix = gradient_color(~r_s1_g);
        default:   w_pix = gradient_color(r_s1_g);
      endcase
    end
  end

  // Stage 2: register the colour; it holds between valid results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_vld   <= 1'b0;
      r_s2_color <= BLACK;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_color <= w_pix;
      end
    end
  end

  assign color_valid = r_s2_vld;
  assign color       = r_s2_color;
  assign bar_level   = w_bar;
  assign peak_level  = w_peak;

endmodule

// File: tb/tb_level_bar_renderer.sv
// Randomized and directed check of level_bar_renderer against a behavioural model.
// Latency: model expects each query result 2 cycles after the query cycle.
// Backpressure: none; queries and samples are driven freely every cycle.
module tb_level_bar_renderer;

  localparam int LW = 5;
  localparam int HT = 2;
  localparam int DS = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [1:0]    mode;
  logic          peak_en;
  logic          level_valid;
  logic [LW-1:0] level_in;
  logic          tick;
  logic          query_valid;
  logic [LW-1:0] query_row;
  logic          color_valid;
  logic [11:0]   color;
  logic [LW-1:0] bar_level;
  logic [LW-1:0] peak_level;

  int errors = 0;
  int checks = 0;

  level_bar_renderer #(
    .LEVEL_W    (LW),
    .HOLD_TICKS (HT),
    .DECAY_STEP (DS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .peak_en     (peak_en),
    .level_valid (level_valid),
    .level_in    (level_in),
    .tick        (tick),
    .query_valid (query_valid),
    .query_row   (query_row),
    .color_valid (color_valid),
    .color       (color),
    .bar_level   (bar_level),
    .peak_level  (peak_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [11:0] c;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  bit          armed = 0;
  int          m_bar = 0;
  int          m_peak = 0;
  int          m_hold = 0;
  logic [11:0] m_last = 12'h000;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [11:0] m_grad(input int g);
    int r;
    int gr;
    if (g < 16) begin
      r = 15; gr = g;
    end else begin
      r = 31 - g; gr = 15;
    end
    return 12'(r * 256 + gr * 16);
  endfunction

  function automatic logic [11:0] m_pix(input int row, input int bar, input int peak,
                                        input bit en, input int md, input bit pen);
    int g;
    g = (row * 32) / (1 << LW);
    if (!en) return 12'h000;
    if (pen && row == peak && peak != 0) return 12'hFFF;
    if (row < bar) begin
      if (md == 1) return 12'h0F0;
      if (md == 2) return m_grad(31 - g);
      return m_grad(g);
    end
    return 12'h000;
  endfunction

  always @(posedge clk) begin
    int dec;
    int nb;
    cyc++;
    if (reset) begin
      armed  = 1;
      m_bar  = 0;
      m_peak = 0;
      m_hold = 0;
      m_last = 12'h000;
      exp_q.delete();
    end else begin
      if (query_valid)
        exp_q.push_back('{cyc + 1, m_pix(int'(query_row), m_bar, m_peak, enable, int'(mode), peak_en)});
      dec = tick ? imax(m_bar - DS, 0) : m_bar;
      nb  = level_valid ? imax(int'(level_in), dec) : dec;
      if (level_valid && int'(level_in) >= m_peak) begin
        m_peak = int'(level_in);
        m_hold = HT;
      end else if (tick) begin
        if (m_hold > 0) m_hold--;
        else m_peak = imax(imax(m_peak - DS, 0), nb);
      end
      m_bar = nb;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    bit exp_v;
    if (armed) begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("bar_level", 32'(bar_level), m_bar);
      chk("peak_level", 32'(peak_level), m_peak);
      chk("color_valid", 32'(color_valid), 32'(exp_v));
      if (exp_v) begin
        m_last = exp_q[0].c;
        exp_q.pop_front();
      end
      chk("color", 32'(color), 32'(m_last));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_query(input int row, input logic [11:0] exp);
    query_valid = 1'b1;
    query_row   = LW'(row);
    step();
    query_valid = 1'b0;
    chk("lat1_no_valid", 32'(color_valid), 0);
    step();
    chk("lat2_valid", 32'(color_valid), 1);
    chk("q_color", 32'(color), 32'(exp));
  endtask

  task automatic send_level(input int v);
    level_valid = 1'b1;
    level_in    = LW'(v);
    step();
    level_valid = 1'b0;
  endtask

  task automatic send_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 2'd0; peak_en = 1'b1;
    level_valid = 1'b0; level_in = '0; tick = 1'b0;
    query_valid = 1'b0; query_row = '0;
    step();
    step();
    reset = 1'b0;
    chk("rst_bar", 32'(bar_level), 0);
    chk("rst_peak", 32'(peak_level), 0);
    chk("rst_cv", 32'(color_valid), 0);
    chk("rst_color", 32'(color), 0);

    // Empty bar: every row is background.
    for (int r = 0; r < 32; r++) do_query(r, 12'h000);

    // Level 20, gradient endpoints and peak marker.
    send_level(20);
    chk("l20_bar", 32'(bar_level), 20);
    chk("l20_peak", 32'(peak_level), 20);
    do_query(0, 12'hF00);
    do_query(15, 12'hFF0);
    do_query(16, 12'hFF0);
    do_query(19, 12'hCF0);
    do_query(20, 12'hFFF);
    do_query(21, 12'h000);

    // Hold for two ticks, then the peak starts to fall.
    send_tick();
    chk("t1_bar", 32'(bar_level), 19);
    chk("t1_peak", 32'(peak_level), 20);
    send_tick();
    chk("t2_bar", 32'(bar_level), 18);
    chk("t2_peak", 32'(peak_level), 20);
    send_tick();
    chk("t3_bar", 32'(bar_level), 17);
    chk("t3_peak", 32'(peak_level), 19);

    // Simultaneous sample and tick: decayed bar 11 beats sample 10.
    reset = 1'b1;
    step();
    reset = 1'b0;
    send_level(12);
    chk("l12_bar", 32'(bar_level), 12);
    level_valid = 1'b1; level_in = LW'(10); tick = 1'b1;
    step();
    level_valid = 1'b0; tick = 1'b0;
    chk("both_bar", 32'(bar_level), 11);
    chk("both_peak", 32'(peak_level), 12);

    // Full bar: modes, enable and peak marker at the top row.
    send_level(31);
    mode = 2'd2; do_query(0, 12'h0F0);
    mode = 2'd1; do_query(5, 12'h0F0);
    mode = 2'd3; do_query(5, 12'hF50);
    mode = 2'd0; enable = 1'b0; do_query(5, 12'h000);
    enable = 1'b1;
    do_query(31, 12'hFFF);
    peak_en = 1'b0; do_query(31, 12'h000);
    peak_en = 1'b1;
    do_query(30, 12'h1F0);

    // Back-to-back queries with reset landing on the third one.
    query_valid = 1'b1; query_row = LW'(3);
    step();
    query_row = LW'(4);
    step();
    chk("bb_q1_valid", 32'(color_valid), 1);
    chk("bb_q1_color", 32'(color), 32'(12'hF30));
    query_row = LW'(5); reset = 1'b1;
    step();
    chk("bb_rst_valid", 32'(color_valid), 0);
    chk("bb_rst_color", 32'(color), 0);
    chk("bb_rst_bar", 32'(bar_level), 0);
    chk("bb_rst_peak", 32'(peak_level), 0);
    query_row = LW'(6);
    step();
    chk("bb_q4_valid", 32'(color_valid), 0);
    reset = 1'b0; query_valid = 1'b0;
    step();
    chk("bb_after1", 32'(color_valid), 0);
    step();
    chk("bb_after2", 32'(color_valid), 0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 4000; i++) begin
      level_valid = ($urandom_range(0, 9) < 3);
      level_in    = LW'($urandom);
      tick        = ($urandom_range(0, 9) < 2);
      query_valid = ($urandom_range(0, 1) == 1);
      query_row   = LW'($urandom);
      reset       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 49) == 0) peak_en = ($urandom_range(0, 3) != 0);
      step();
    end
    level_valid = 1'b0; tick = 1'b0; query_valid = 1'b0; reset = 1'b0;
    step();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/level_bar_renderer.md
Name: level_bar_renderer

Overview:
- Parametrised successor to the combinational level-to-colour gradient.
- Holds a smoothed bar level and a peak-hold marker from a stream of level samples.
- Answers per-pixel row queries with a 12-bit RGB colour: gradient bar, white peak marker, or black background.
- Sits between the audio-level extractor and the OLED/VGA pixel driver.

Parameters:
- LEVEL_W, 5, level and row width; valid range 2..8; levels run 0..2^LEVEL_W-1.
- HOLD_TICKS, 8, number of decay ticks the peak is held before it starts to fall.
- DECAY_STEP, 1, amount the bar and the peak drop per tick.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  0 forces every output colour to 12'h000; state keeps updating.
- mode  in  2  0 gradient, 1 mono green 12'h0F0, 2 inverted gradient, 3 reserved (acts as 0).
- peak_en  in  1  enables drawing of the peak marker.
- level_valid  in  1  strobe qualifying level_in.
- level_in  in  LEVEL_W  new level sample.
- tick  in  1  one-cycle decay strobe (frame rate).
- query_valid  in  1  strobe qualifying query_row.
- query_row  in  LEVEL_W  row index; 0 = bottom of the bar.
- color_valid  out  1  qualifies color, exactly 2 cycles after query_valid.
- color  out  12  RGB444 pixel colour.
- bar_level  out  LEVEL_W  current bar register.
- peak_level  out  LEVEL_W  current peak register.

Behaviour:
- Reset values: bar_level=0, peak_level=0, hold counter=0, pipeline valids=0, color_valid=0, color=12'h000.
- Reset asserted mid-query discards the in-flight result; no color_valid follows.
- Bar update, evaluated every cycle:
  - dec = bar_level - DECAY_STEP if tick is high, else bar_level; saturates at 0.
  - Next bar_level = max(level_in, dec) if level_valid is high, else dec.
  - When level_valid and tick arrive in the same cycle, the larger of the new level and the decayed bar wins.
- Peak update:
  - If level_valid and level_in >= peak_level: peak_level <= level_in and hold counter <= HOLD_TICKS.
  - Otherwise, on tick, if the hold counter is nonzero it decrements.
  - Otherwise, on tick, peak_level <= max(peak_level - DECAY_STEP, bar_next), saturating at 0. The peak never sits below the bar.
- Query pipeline, 2-cycle latency, fully pipelined, one query accepted per cycle with no stall:
  - Stage 1 registers the row, the comparison flags against bar_level/peak_level as sampled in the query cycle, and the gradient index.
  - Stage 2 registers color.
- Gradient index g is 5 bits: row << (5-LEVEL_W) if LEVEL_W<=5, else row >> (LEVEL_W-5).
- Gradient colour of g:
  - g<=15: R=F, G=g, B=0.
  - g>=16: R=31-g, G=F, B=0.
  - Endpoints: g=0 gives 12'hF00, g=15 and g=16 give 12'hFF0, g=31 gives 12'h0F0.
  - Mode 2 uses index 31-g.
- Pixel priority, highest first:
  - enable=0 gives 12'h000.
  - peak_en and row==peak_level and peak_level!=0 gives 12'hFFF.
  - row < bar_level gives the mode colour.
  - Otherwise 12'h000.
- color holds its last value when color_valid=0.

Decomposition:
- Package level_bar_pkg holds:
  - the colour constants BLACK=12'h000, WHITE=12'hFFF, MONO=12'h0F0;
  - the mode encodings;
  - the pure function gradient_color(g[4:0]) returning 12 bits.
- One natural sub-module: level_peak_tracker, which owns the bar, peak and hold-counter registers. The top level adds the query pipeline and colour mux.

Test Plan:
- Reset, then query rows 0..31 with LEVEL_W=5 and no levels sent -> every color is 12'h000, color_valid arrives 2 cycles after each query, bar_level=0 and peak_level=0.
- level_in=20, then queries on rows 0, 15, 16, 19, 20 in gradient mode -> 12'hF00, 12'hFF0, 12'hFF0, 12'hCF0, then 12'hFFF (peak marker).
- After level 20, send 3 ticks with HOLD_TICKS=2 -> bar_level=17; peak_level stays 20 for 2 ticks, then becomes 19.
- level_valid with level_in=10 and tick in the same cycle while bar_level=12 -> bar_level=11, peak unchanged.
- mode=2 with bar_level=31, row 0 -> 12'h0F0; mode=1, row 5 -> 12'h0F0; enable=0 -> 12'h000.
- Back-to-back queries on 4 consecutive cycles with reset asserted in the 3rd cycle -> only the first result appears (cycle 3); the second query's result is dropped; all registers are zero after reset.
